nonce_word_streamer: RTL and testbench

// Consumes the 288-bit seed from the LFSR sequence generator (256 random bits + 32-bit zero nonce slot).

---
 rtl/nonce_word_streamer.sv | 199 +++++++++++++++++++
 tb/tb_nonce_word_streamer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_word_streamer.sv
// Nonce search sequencer: captures a seed, streams 9-word messages (8 seed words + nonce)
// into the hash core and steps the nonce until a hit or the nonce space runs out.
module nonce_word_streamer #(
  parameter logic [31:0] MaxNonce = 32'hFFFF_FFFF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  output logic         lfsr_enable_o,
  input  logic [287:0] random_sequence_i,
  input  logic         done_creating_sequence_i,
  output logic [31:0]  word_data_o,
  output logic         word_valid_o,
  input  logic         word_ready_i,
  output logic         word_first_o,
  output logic         word_last_o,
  input  logic         result_valid_i,
  input  logic         result_hit_i,
  output logic [31:0]  nonce_out_o,
  output logic [31:0]  found_nonce_o,
  output logic         success_o,
  output logic         exhausted_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSeed,
    StSend,
    StWaitResult,
    StFound,
    StExhausted
  } state_e;

  state_e state_q, state_d;

  // Word 0 of the message is the top word of the seed, so it lives in seed_q[7].
  logic [7:0][31:0] seed_q, seed_d;
  logic [31:0]      nonce_q, nonce_d;
  logic [31:0]      found_q, found_d;
  logic [3:0]       idx_q, idx_d;
  logic             success_q, success_d;
  logic             exhausted_q, exhausted_d;

  logic             xfer;
  logic             last_word;
  logic             out_of_nonces;
  logic             unused_nonce_slot;

  // The upstream nonce slot is always zero and is replaced by our own counter.
  assign unused_nonce_slot = ^random_sequence_i[31:0];

  assign xfer          = (state_q == StSend) && word_ready_i;
  assign last_word     = (idx_q == 4'd8);
  assign out_of_nonces = (nonce_q == MaxNonce);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks start and verdicts
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (start_i) state_d = StWaitSeed;
        end
        StWaitSeed: begin
          if (done_creating_sequence_i) state_d = StSend;
        end
        StSend: begin
          if (xfer && last_word) state_d = StWaitResult;
        end
        StWaitResult: begin
          if (result_valid_i) begin
            if (result_hit_i) begin
              state_d = StFound;
            end else if (out_of_nonces) begin
              state_d = StExhausted;
            end else begin
              state_d = StSend;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_q      <= '0;
      nonce_q     <= '0;
      found_q     <= '0;
      idx_q       <= '0;
      success_q   <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      seed_q      <= seed_d;
      nonce_q     <= nonce_d;
      found_q     <= found_d;
      idx_q       <= idx_d;
      success_q   <= success_d;
      exhausted_q <= exhausted_d;
    end
  end

  always_comb begin
    seed_d      = seed_q;
    nonce_d     = nonce_q;
    found_d     = found_q;
    idx_d       = idx_q;
    success_d   = success_q;
    exhausted_d = exhausted_q;
    if (abort_i) begin
      nonce_d     = '0;
      idx_d       = '0;
      success_d   = 1'b0;
      exhausted_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (start_i) begin
            found_d     = '0;
            success_d   = 1'b0;
            exhausted_d = 1'b0;
          end
        end
        StWaitSeed: begin
          if (done_creating_sequence_i) begin
            seed_d  = random_sequence_i[287:32];
            nonce_d = '0;
            idx_d   = '0;
          end
        end
        StSend: begin
          if (xfer) idx_d = idx_q + 4'd1;
        end
        StWaitResult: begin
          if (result_valid_i) begin
            if (result_hit_i) begin
              found_d   = nonce_q;
              success_d = 1'b1;
            end else if (out_of_nonces) begin
              exhausted_d = 1'b1;
            end else begin
              nonce_d = nonce_q + 32'd1;
              idx_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state only, so an async reset clears them at once
  always_comb begin
    word_valid_o  = 1'b0;
    word_data_o   = '0;
    word_first_o  = 1'b0;
    word_last_o   = 1'b0;
    lfsr_enable_o = 1'b0;
    busy_o        = 1'b0;
    case (state_q)
      StWaitSeed: begin
        lfsr_enable_o = 1'b1;
        busy_o        = 1'b1;
      end
      StSend: begin
        busy_o       = 1'b1;
        word_valid_o = 1'b1;
        word_first_o = (idx_q == 4'd0);
        word_last_o  = last_word;
        word_data_o  = last_word ? nonce_q : seed_q[3'd7 - idx_q[2:0]];
      end
      StWaitResult: begin
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign nonce_out_o   = nonce_q;
  assign found_nonce_o = found_q;
  assign success_o     = success_q;
  assign exhausted_o   = exhausted_q;

endmodule

// File: tb/tb_nonce_word_streamer.sv
// Bench for nonce_word_streamer: a behavioural message-level model is checked against the DUT
// on every falling edge, plus literal expectations for the directed scenarios.
module tb_nonce_word_streamer;

  localparam logic [31:0] MaxN = 32'd2;

  localparam int PIdle  = 0;
  localparam int PSeed  = 1;
  localparam int PSend  = 2;
  localparam int PRes   = 3;
  localparam int PFound = 4;
  localparam int PExh   = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, done = 1'b0;
  logic [287:0] seq = '0;
  logic         word_ready = 1'b0, result_valid = 1'b0, result_hit = 1'b0;
  logic         lfsr_enable, word_valid, word_first, word_last, success, exhausted, busy;
  logic [31:0]  word_data, nonce_out, found_nonce;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nonce_word_streamer #(.MaxNonce(MaxN)) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .start_i                  (start),
    .abort_i                  (abort),
    .lfsr_enable_o            (lfsr_enable),
    .random_sequence_i        (seq),
    .done_creating_sequence_i (done),
    .word_data_o              (word_data),
    .word_valid_o             (word_valid),
    .word_ready_i             (word_ready),
    .word_first_o             (word_first),
    .word_last_o              (word_last),
    .result_valid_i           (result_valid),
    .result_hit_i             (result_hit),
    .nonce_out_o              (nonce_out),
    .found_nonce_o            (found_nonce),
    .success_o                (success),
    .exhausted_o              (exhausted),
    .busy_o                   (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: message phase, seed as a word list, nonce, word position, verdict flags.
  int          m_ph;
  logic [31:0] m_w [8];
  logic [31:0] m_nonce, m_found;
  int          m_idx;
  logic        m_succ, m_exh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= PIdle; m_nonce <= 0; m_found <= 0; m_idx <= 0; m_succ <= 0; m_exh <= 0;
      for (int i = 0; i < 8; i++) m_w[i] <= 0;
    end else if (abort) begin
      m_ph <= PIdle; m_nonce <= 0; m_idx <= 0; m_succ <= 0; m_exh <= 0;
    end else begin
      case (m_ph)
        PIdle, PFound, PExh: if (start) begin
          m_ph <= PSeed; m_succ <= 0; m_exh <= 0; m_found <= 0;
        end
        PSeed: if (done) begin
          for (int i = 0; i < 8; i++) m_w[i] <= seq[287 - 32*i -: 32];
          m_nonce <= 0; m_idx <= 0; m_ph <= PSend;
        end
        PSend: if (word_ready) begin
          if (m_idx == 8) m_ph <= PRes;
          else m_idx <= m_idx + 1;
        end
        PRes: if (result_valid) begin
          if (result_hit) begin
            m_ph <= PFound; m_found <= m_nonce; m_succ <= 1;
          end else if (m_nonce == MaxN) begin
            m_ph <= PExh; m_exh <= 1;
          end else begin
            m_nonce <= m_nonce + 1; m_idx <= 0; m_ph <= PSend;
          end
        end
        default: m_ph <= PIdle;
      endcase
    end
  end

  // Transfer log: {first, last, data} of every accepted word
  logic [33:0] lg[$];

  always @(negedge clk) begin : compare
    logic        ev;
    logic [31:0] ed;
    ev = (m_ph == PSend);
    ed = !ev ? 32'd0 : (m_idx < 8 ? m_w[m_idx] : m_nonce);
    chk("word_valid", 32'(word_valid), 32'(ev));
    chk("word_data", word_data, ed);
    chk("word_first", 32'(word_first), 32'(ev && m_idx == 0));
    chk("word_last", 32'(word_last), 32'(ev && m_idx == 8));
    chk("lfsr_enable", 32'(lfsr_enable), 32'(m_ph == PSeed));
    chk("busy", 32'(busy), 32'(m_ph == PSeed || m_ph == PSend || m_ph == PRes));
    chk("nonce_out", nonce_out, m_nonce);
    chk("found_nonce", found_nonce, m_found);
    chk("success", 32'(success), 32'(m_succ));
    chk("exhausted", 32'(exhausted), 32'(m_exh));
    if (rst_n && word_valid && word_ready && !abort)
      lg.push_back({word_first, word_last, word_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_seed(input logic [287:0] s, input int dly);
    repeat (dly) tick();
    done = 1'b1;
    seq  = s;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_ph(input int ph, input bit rnd, input int bud);
    int n = 0;
    while (m_ph != ph && n < bud) begin
      if (rnd) begin
        word_ready   = 1'($urandom_range(0, 1));
        result_valid = ($urandom_range(0, 7) == 0) && (m_ph != PRes);
        result_hit   = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    result_valid = 1'b0;
    result_hit   = 1'b0;
    if (m_ph != ph) begin
      total++;
      bad++;
      $display("FAIL wait_phase: phase %0d still not reached, required %0d", m_ph, ph);
    end
  endtask

  task automatic verdict(input bit hit, input int dly, input bit rnd);
    wait_ph(PRes, rnd, 300);
    repeat (dly) tick();
    result_valid = 1'b1;
    result_hit   = hit;
    tick();
    result_valid = 1'b0;
    result_hit   = 1'b0;
  endtask

  task automatic check_msg(input logic [31:0] e[9]);
    chk("msg_len", 32'(lg.size()), 32'd9);
    for (int i = 0; i < 9 && i < lg.size(); i++) begin
      chk("msg_word", lg[i][31:0], e[i]);
      chk("msg_first", 32'(lg[i][33]), 32'(i == 0));
      chk("msg_last", 32'(lg[i][32]), 32'(i == 8));
    end
  endtask

  function automatic logic [287:0] rnd_seq();
    logic [287:0] s;
    for (int i = 0; i < 9; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    logic [31:0]  e[9];
    logic [287:0] s;
    int           cnt;
    int           firsts;
    int           k;

    // 1: reset held with random inputs
    repeat (10) begin
      start = 1'($urandom_range(0, 1)); abort = 1'($urandom_range(0, 1));
      done = 1'($urandom_range(0, 1)); seq = rnd_seq(); word_ready = 1'($urandom_range(0, 1));
      result_valid = 1'($urandom_range(0, 1)); result_hit = 1'($urandom_range(0, 1));
      tick();
    end
    start = 0; abort = 0; done = 0; word_ready = 0; result_valid = 0; result_hit = 0;
    rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lfsr", 32'(lfsr_enable), 32'd0);

    // 2: seed after 130 cycles, full-rate message 1..8,0
    do_start();
    cnt = 0;
    s = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hDEAD_BEEF};
    for (int i = 0; i < 130; i++) begin
      if (lfsr_enable) cnt++;
      if (i == 129) begin done = 1'b1; seq = s; end
      tick();
    end
    done = 1'b0;
    if (lfsr_enable) cnt++;
    chk("lfsr_cycles", 32'(cnt), 32'd130);
    chk("first_word_latency", word_data, 32'd1);
    lg.delete();
    word_ready = 1'b1;
    wait_ph(PRes, 1'b0, 50);
    e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
    check_msg(e);

    // 3 + 4: miss on nonce 0, stall at idx 3 in the second message, hit on nonce 1
    lg.delete();
    verdict(1'b0, 2, 1'b0);
    wait_ph(PSend, 1'b0, 10);
    while (m_idx != 3) tick();
    word_ready = 1'b0;
    repeat (5) begin
      chk("stall_data", word_data, 32'd4);
      chk("stall_valid", 32'(word_valid), 32'd1);
      tick();
    end
    word_ready = 1'b1;
    wait_ph(PRes, 1'b0, 50);
    e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd1};
    check_msg(e);
    verdict(1'b1, 0, 1'b0);
    chk("hit_found", found_nonce, 32'd1);
    chk("hit_success", 32'(success), 32'd1);
    chk("hit_busy", 32'(busy), 32'd0);

    // 5: exhaustion with random backpressure and stray verdicts
    lg.delete();
    do_start();
    give_seed(rnd_seq(), $urandom_range(0, 5));
    for (int m = 0; m < 3; m++) verdict(1'b0, $urandom_range(0, 4), 1'b1);
    chk("exh_flag", 32'(exhausted), 32'd1);
    chk("exh_found", found_nonce, 32'd0);
    chk("exh_success", 32'(success), 32'd0);
    word_ready = 1'b1;
    repeat (20) begin
      result_valid = 1'($urandom_range(0, 1));
      tick();
    end
    result_valid = 1'b0;
    firsts = 0;
    foreach (lg[i]) if (lg[i][33]) firsts++;
    chk("exh_msgs", 32'(firsts), 32'd3);

    // 6a: async reset at idx 4, then a clean message
    do_start();
    give_seed(rnd_seq(), 3);
    while (m_idx != 4) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_data", word_data, 32'd0);
    chk("arst_nonce", nonce_out, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    lg.delete();
    s = rnd_seq();
    do_start();
    give_seed(s, 2);
    wait_ph(PRes, 1'b0, 50);
    for (int i = 0; i < 8; i++) e[i] = s[287 - 32*i -: 32];
    e[8] = 32'd0;
    check_msg(e);

    // 6b: abort at idx 4, then a clean message
    verdict(1'b0, 0, 1'b0);
    while (m_idx != 4) tick();
    abort = 1'b1;
    word_ready = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(word_valid), 32'd0);
    chk("abort_nonce", nonce_out, 32'd0);
    lg.delete();
    s = rnd_seq();
    do_start();
    give_seed(s, 1);
    word_ready = 1'b1;
    wait_ph(PRes, 1'b0, 50);
    for (int i = 0; i < 8; i++) e[i] = s[287 - 32*i -: 32];
    check_msg(e);
    verdict(1'b1, 1, 1'b0);

    // Random searches: hit at nonce k, or exhaust when k == 3
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(0, 3);
      do_start();
      give_seed(rnd_seq(), $urandom_range(0, 20));
      for (int m = 0; m <= k && m < 3; m++) verdict(m == k, $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
